// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: selectable bitwise gate on two operands with an elastic valid/ready pipeline
//   clk/rst_n            clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake carrying a, b and op (000 AND .. 111 PASS)
//   out_valid/out_ready  result handshake carrying y and its OR/AND reduction flags
//   result_count         wrapping count of delivered results
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_any,
  output logic             y_all,
  output logic [CNT_W-1:0] result_count
);
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("logic_gate_pipe: STAGES must be 1..4");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("logic_gate_pipe: WIDTH must be 1..64");
  end
  logic [WIDTH-1:0] res_d;
  logic [STAGES:0]  rdy;
  logic [STAGES-1:0] vld, any_f, all_f;
  logic [WIDTH-1:0] ys [STAGES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    case (op)
      3'b000:  res_d = a & b;
      3'b001:  res_d = a | b;
      3'b010:  res_d = a ^ b;
      3'b011:  res_d = ~(a & b);
      3'b100:  res_d = ~(a | b);
      3'b101:  res_d = ~(a ^ b);
      3'b110:  res_d = a & ~b;
      default: res_d = a;
    endcase
  end
  assign rdy[STAGES] = out_ready;
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             v_in, any_in, all_in;
    logic [WIDTH-1:0] y_in;
    logic             v_q, any_q, all_q;
    logic [WIDTH-1:0] d_q;
    if (s == 0) begin : g_head
      assign v_in   = in_valid;
      assign y_in   = res_d;
      assign any_in = |res_d;
      assign all_in = &res_d;
    end else begin : g_body
      assign v_in   = vld[s-1];
      assign y_in   = ys[s-1];
      assign any_in = any_f[s-1];
      assign all_in = all_f[s-1];
    end
    // a stage with no valid beat always takes new data, so bubbles collapse under a stall
    assign rdy[s]   = !v_q || rdy[s+1];
    assign vld[s]   = v_q;
    assign ys[s]    = d_q;
    assign any_f[s] = any_q;
    assign all_f[s] = all_q;
    // payload only moves with a valid beat so idle outputs keep their last value
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        d_q   <= '0;
        any_q <= 1'b0;
        all_q <= 1'b0;
      end else if (rdy[s]) begin
        v_q <= v_in;
        if (v_in) begin
          d_q   <= y_in;
          any_q <= any_in;
          all_q <= all_in;
        end
      end
    end
  end
  assign in_ready     = rdy[0];
  assign out_valid    = vld[STAGES-1];
  assign y            = ys[STAGES-1];
  assign y_any        = any_f[STAGES-1];
  assign y_all        = all_f[STAGES-1];
  assign cnt_d        = cnt_q + CNT_W'(out_valid && out_ready);
  assign result_count = cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
- Parametrised, pipelined successor to the single-bit two-input gate.
- Computes one of eight selectable bitwise operations on two WIDTH-bit operands, plus reduction flags.
- Result travels through a STAGES-deep elastic pipeline with valid/ready handshakes on both sides.
- Keeps a running count of delivered results; sits between an operand producer and a result consumer.

Parameters:
- WIDTH, 8, operand/result width in bits; legal 1..64.
- STAGES, 2, pipeline register stages; legal 1..4; any other value fails elaboration.
- CNT_W, 16, width of the delivered-result counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation select, sampled with the beat.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- y  out  WIDTH  result.
- y_any  out  1  OR-reduction of y.
- y_all  out  1  AND-reduction of y.
- result_count  out  CNT_W  number of results delivered since reset.

Behaviour:
- Reset: sampled on a rising edge with rst_n=0. Clears every stage-valid bit, out_valid=0, y=0, y_any=0, y_all=0, result_count=0. in_ready=1 in the first cycle after reset. Reset mid-operation discards all in-flight beats; none are delivered.
- Op encoding:
  - 000 AND, 001 OR, 010 XOR
  - 011 NAND, 100 NOR, 101 XNOR
  - 110 ANDN (a & ~b), 111 PASS (y=a)
- Compute point: the result is computed in the acceptance cycle and registered into stage 1, together with y_any/y_all derived from that result. Later stages carry the registered values unchanged.
- Transfers: an input beat transfers when in_valid and in_ready are both 1 at a rising edge. An output beat transfers when out_valid and out_ready are both 1.
- Stage flow: stage i holds {valid, y, y_any, y_all}.
  - ready_i = !valid_i || ready_(i+1), with ready_(STAGES+1) = out_ready.
  - in_ready = ready_1.
  - out_valid = valid_STAGES; y, y_any, y_all come from stage STAGES.
- Latency: a beat accepted in cycle N appears with out_valid=1 in cycle N+STAGES when no stall occurs. Throughput is one beat per cycle while out_ready=1.
- Backpressure:
  - While out_ready=0, stage contents hold and no beat is lost or duplicated.
  - Bubbles compress: a stage with valid=0 accepts new data even while downstream stalls.
  - Capacity is STAGES beats. in_ready drops once all stages are valid and out_ready=0.
- Stable outputs: while out_valid=1 and out_ready=0, y, y_any and y_all hold stable.
- Idle outputs: when out_valid=0, y, y_any and y_all keep their last-registered values; the consumer must ignore them.
- Simultaneous accept and deliver with a full pipe and out_ready=1: in_ready=1 in that cycle and occupancy stays unchanged.
- Counter: result_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Combinational paths: in_ready depends combinationally on out_ready. No combinational path from a, b, op or in_valid to any output.

Test Plan:
- Truth table: WIDTH=1, STAGES=1, out_ready=1; drive (a,b) = 00, 01, 10, 11 for each op. AND gives y=0,0,0,1; XOR gives 0,1,1,0; NOR gives 1,0,0,0. Each result appears exactly one cycle after acceptance, and result_count ends at 32.
- Width and flags: WIDTH=8, STAGES=2, op=010, a=8'hF0, b=8'hFF. Expect y=8'h0F, y_any=1, y_all=0, out_valid high 2 cycles after acceptance. Then op=011, a=8'h00, b=8'h00 gives y=8'hFF, y_all=1.
- Backpressure: STAGES=3, stream 6 back-to-back beats with out_ready held 0. Expect in_ready=0 after 3 acceptances. Release out_ready and expect all 6 results delivered in order with no gaps, result_count=6.
- Bubble compression: STAGES=3, accept one beat, stall out_ready, then offer 2 more. Expect both accepted while stalled and in_ready=0 only once 3 beats are held.
- Reset mid-flight: STAGES=4 with 3 beats in flight; assert rst_n=0 for one edge. Expect out_valid=0, result_count=0, in_ready=1 next cycle, and none of the 3 beats ever emitted.
- Counter wrap: CNT_W=4, deliver 17 results. Expect result_count to go 15 → 0 → 1.
